fetch_sequencer: RTL and testbench

Controller for the fetch-stage program counter in the pipelined MIPS core. Owns the fetch PC, selects the next PC from sequential, branch, jump and (optionally) exception sources, and drives a req/ack handshake to instruction memory. Delivers fetched words to the F/D boundary with hazard-unit stall, a one-entry skid buffer for words returned while stalled, and squash of wrong-path words.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/pc_redirect_select.sv | 33 +++
 rtl/fetch_sequencer.sv | 164 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and state type for the fetch sequencer
package fetch_pkg;

  localparam logic [31:0] FETCH_RESET_VECTOR = 32'h0040_0000;
  localparam logic [31:0] FETCH_EXC_VECTOR   = 32'h8000_0180;
  localparam logic [31:0] PC_INCR            = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HELD  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_redirect_select.sv
// rtl/pc_redirect_select.sv - priority select of the next fetch PC and redirect flag
// Priority exc > jump > branch; decode-stage redirects are ignored while stalled.
module pc_redirect_select
  import fetch_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = FETCH_EXC_VECTOR
) (
  input  logic        i_stall_f,
  input  logic        i_exc_req,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic [31:0] i_fetch_pc,
  output logic        o_redirect,
  output logic [31:0] o_next_pc
);

  always_comb begin
    o_redirect = 1'b1;
    o_next_pc  = i_fetch_pc + PC_INCR;
    if (i_exc_req) begin
      o_next_pc = EXC_VECTOR;
    end else if (!i_stall_f && i_jump) begin
      o_next_pc = i_jump_target;
    end else if (!i_stall_f && i_branch_taken) begin
      o_next_pc = i_branch_target;
    end else begin
      o_redirect = 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch PC owner, imem req/ack handshake and F-stage delivery
// FETCH_EXCEPTION_EN adds the exc_req port and the EXC_VECTOR redirect.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = FETCH_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = FETCH_EXC_VECTOR
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall_f,
  input  logic        branch_taken_d,
  input  logic [31:0] branch_target_d,
  input  logic        jump_d,
  input  logic [31:0] jump_target_d,
`ifdef FETCH_EXCEPTION_EN
  input  logic        exc_req,
`endif
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus4_f,
  output logic        valid_f
);

  fetch_state_t r_state;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_skid_instr;
  logic [31:0]  r_skid_pc;
  logic [31:0]  r_pending_target;
  logic         r_squash;
  logic [31:0]  r_instr_f;
  logic [31:0]  r_pc_f;
  logic [31:0]  r_pc_plus4_f;
  logic         r_valid_f;

  logic         w_exc_req;
  logic         w_redirect;
  logic         w_ack;
  logic [31:0]  w_next_pc;

`ifdef FETCH_EXCEPTION_EN
  assign w_exc_req = exc_req;
`else
  assign w_exc_req = 1'b0;
`endif

  // Once a request is out in WAIT it stays up with a stable address until acked.
  assign imem_req   = (r_state == WAIT) || ((r_state == FETCH) && !stall_f);
  assign imem_addr  = r_fetch_pc;
  assign w_ack      = imem_req && imem_ack;

  assign instr_f    = r_instr_f;
  assign pc_f       = r_pc_f;
  assign pc_plus4_f = r_pc_plus4_f;
  assign valid_f    = r_valid_f;

  pc_redirect_select #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_pc_redirect_select (
    .i_stall_f      (stall_f),
    .i_exc_req      (w_exc_req),
    .i_jump         (jump_d),
    .i_jump_target  (jump_target_d),
    .i_branch_taken (branch_taken_d),
    .i_branch_target(branch_target_d),
    .i_fetch_pc     (r_fetch_pc),
    .o_redirect     (w_redirect),
    .o_next_pc      (w_next_pc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= BOOT;
      r_fetch_pc       <= RESET_VECTOR;
      r_skid_instr     <= 32'h0;
      r_skid_pc        <= 32'h0;
      r_pending_target <= 32'h0;
      r_squash         <= 1'b0;
      r_instr_f        <= 32'h0;
      r_pc_f           <= 32'h0;
      r_pc_plus4_f     <= 32'h0;
      r_valid_f        <= 1'b0;
    end else begin
      if (!stall_f) begin
        r_valid_f <= 1'b0;
      end
      case (r_state)
        BOOT: begin
          if (w_redirect) begin
            r_fetch_pc <= w_next_pc;
          end
          r_state <= FETCH;
        end
        FETCH: begin
          if (w_redirect) begin
            if (w_ack || !imem_req) begin
              r_fetch_pc <= w_next_pc;
            end else begin
              // Unaccepted request must stay on the bus; retire it as wrong-path.
              r_squash         <= 1'b1;
              r_pending_target <= w_next_pc;
              r_state          <= WAIT;
            end
          end else if (w_ack) begin
            r_instr_f    <= imem_rdata;
            r_pc_f       <= r_fetch_pc;
            r_pc_plus4_f <= r_fetch_pc + PC_INCR;
            r_valid_f    <= 1'b1;
            r_fetch_pc   <= w_next_pc;
          end else if (imem_req) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (w_ack) begin
            r_squash <= 1'b0;
            r_state  <= FETCH;
            if (w_redirect) begin
              r_fetch_pc <= w_next_pc;
            end else if (r_squash) begin
              r_fetch_pc <= r_pending_target;
            end else begin
              r_fetch_pc <= w_next_pc;
              if (!stall_f) begin
                r_instr_f    <= imem_rdata;
                r_pc_f       <= r_fetch_pc;
                r_pc_plus4_f <= r_fetch_pc + PC_INCR;
                r_valid_f    <= 1'b1;
              end else begin
                r_skid_instr <= imem_rdata;
                r_skid_pc    <= r_fetch_pc;
                r_state      <= HELD;
              end
            end
          end else if (w_redirect) begin
            r_squash         <= 1'b1;
            r_pending_target <= w_next_pc;
          end
        end
        HELD: begin
          if (w_redirect) begin
            r_fetch_pc <= w_next_pc;
            r_state    <= FETCH;
          end else if (!stall_f) begin
            r_instr_f    <= r_skid_instr;
            r_pc_f       <= r_skid_pc;
            r_pc_plus4_f <= r_skid_pc + PC_INCR;
            r_valid_f    <= 1'b1;
            r_state      <= FETCH;
          end
        end
        default: r_state <= BOOT;
      endcase
      if (w_redirect) begin
        r_valid_f <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
// FETCH_EXCEPTION_EN enables the exc_req scenarios.
module tb_fetch_sequencer;

  localparam logic [31:0] RV = 32'h0040_0000;
  localparam logic [31:0] EV = 32'h8000_0180;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall_f = 1'b0;
  logic        branch_taken_d = 1'b0;
  logic [31:0] branch_target_d = 32'h0;
  logic        jump_d = 1'b0;
  logic [31:0] jump_target_d = 32'h0;
  logic        exc_req = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic        valid_f;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  fetch_sequencer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .stall_f        (stall_f),
    .branch_taken_d (branch_taken_d),
    .branch_target_d(branch_target_d),
    .jump_d         (jump_d),
    .jump_target_d  (jump_target_d),
`ifdef FETCH_EXCEPTION_EN
    .exc_req        (exc_req),
`endif
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_f        (instr_f),
    .pc_f           (pc_f),
    .pc_plus4_f     (pc_plus4_f),
    .valid_f        (valid_f)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hC3A5_0F1E;
  endfunction

  // Called just after a negedge: sets this cycle's inputs, then answers the request.
  task automatic drive(input logic s, input logic br, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt, input logic e, input logic ack_en);
    stall_f = s; branch_taken_d = br; branch_target_d = bt;
    jump_d = j; jump_target_d = jt; exc_req = e;
    #1;
    imem_ack   = imem_req & ack_en;
    imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
  endtask

  // Leaves the DUT streaming: RV consumed, RV+4 acked, next negedge shows pc_f=RV+4.
  task automatic restart();
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock); reset_n = 1'b1; drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clock); drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clock); drive(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_reset();
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 1);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %0b want 0", imem_req); end
    n_cmp++; if (imem_addr !== RV) begin n_err++; $display("FAIL reset_addr: got %h want %h", imem_addr, RV); end
    n_cmp++; if (instr_f !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", instr_f); end
    n_cmp++; if (pc_f !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", pc_f); end
    n_cmp++; if (pc_plus4_f !== 32'h0) begin n_err++; $display("FAIL reset_pc4: got %h want 0", pc_plus4_f); end
    n_cmp++; if (valid_f !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", valid_f); end
    @(negedge clock); reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1);
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL boot_req: got %0b want 0", imem_req); end
  endtask

  task automatic test_zero_wait();
    @(negedge clock);
    n_cmp++; if (imem_addr !== RV) begin n_err++; $display("FAIL first_addr: got %h want %h", imem_addr, RV); end
    drive(0, 0, 0, 0, 0, 0, 1);
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %0b want 1", imem_req); end
    for (int k = 0; k < 4; k++) begin
      logic [31:0] p;
      p = RV + 32'(4 * k);
      @(negedge clock);
      n_cmp++; if (valid_f !== 1'b1) begin n_err++; $display("FAIL zw_valid[%0d]: got %0b want 1", k, valid_f); end
      n_cmp++; if (pc_f !== p) begin n_err++; $display("FAIL zw_pc[%0d]: got %h want %h", k, pc_f, p); end
      n_cmp++; if (pc_plus4_f !== p + 4) begin n_err++; $display("FAIL zw_pc4[%0d]: got %h want %h", k, pc_plus4_f, p + 4); end
      n_cmp++; if (instr_f !== mem_word(p)) begin n_err++; $display("FAIL zw_instr[%0d]: got %h want %h", k, instr_f, mem_word(p)); end
      n_cmp++; if (imem_addr !== p + 4) begin n_err++; $display("FAIL zw_addr[%0d]: got %h want %h", k, imem_addr, p + 4); end
      drive(0, 0, 0, 0, 0, 0, 1);
    end
  endtask

  task automatic test_stall();
    restart();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_cmp++; if (valid_f !== 1'b1 || pc_f !== RV + 4 || instr_f !== mem_word(RV + 4))
        begin n_err++; $display("FAIL stall_hold[%0d]: got v=%0b pc=%h want v=1 pc=%h", i, valid_f, pc_f, RV + 4); end
      n_cmp++; if (imem_addr !== RV + 8) begin n_err++; $display("FAIL stall_addr[%0d]: got %h want %h", i, imem_addr, RV + 8); end
      drive((i < 3), 0, 0, 0, 0, 0, 1);
      n_cmp++; if (imem_req !== (i == 3)) begin n_err++; $display("FAIL stall_req[%0d]: got %0b want %0b", i, imem_req, (i == 3)); end
    end
    @(negedge clock);
    n_cmp++; if (valid_f !== 1'b1 || pc_f !== RV + 8) begin n_err++; $display("FAIL stall_resume: got v=%0b pc=%h want v=1 pc=%h", valid_f, pc_f, RV + 8); end
  endtask

  task automatic test_branch();
    restart();
    @(negedge clock);
    drive(0, 1, 32'h0040_0100, 0, 0, 0, 1);
    @(negedge clock);
    n_cmp++; if (valid_f !== 1'b0) begin n_err++; $display("FAIL br_bubble: got %0b want 0", valid_f); end
    n_cmp++; if (imem_addr !== 32'h0040_0100) begin n_err++; $display("FAIL br_addr: got %h want 00400100", imem_addr); end
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clock);
    n_cmp++; if (valid_f !== 1'b1 || pc_f !== 32'h0040_0100 || instr_f !== mem_word(32'h0040_0100))
      begin n_err++; $display("FAIL br_target: got v=%0b pc=%h want v=1 pc=00400100", valid_f, pc_f); end
  endtask

  task automatic test_wait_jump();
    restart();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      if (c > 1) begin
        n_cmp++; if (valid_f !== 1'b0) begin n_err++; $display("FAIL wj_valid[%0d]: got %0b want 0", c, valid_f); end
      end
      drive(0, 0, 0, (c == 2), 32'h0040_0200, 0, (c == 4));
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RV + 8)
        begin n_err++; $display("FAIL wj_hold[%0d]: got req=%0b addr=%h want req=1 addr=%h", c, imem_req, imem_addr, RV + 8); end
    end
    @(negedge clock);
    n_cmp++; if (valid_f !== 1'b0) begin n_err++; $display("FAIL wj_squash: got %0b want 0", valid_f); end
    n_cmp++; if (imem_addr !== 32'h0040_0200) begin n_err++; $display("FAIL wj_addr: got %h want 00400200", imem_addr); end
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clock);
    n_cmp++; if (valid_f !== 1'b1 || pc_f !== 32'h0040_0200) begin n_err++; $display("FAIL wj_target: got v=%0b pc=%h want v=1 pc=00400200", valid_f, pc_f); end
  endtask

  task automatic test_held();
    restart();
    @(negedge clock); drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock); drive(1, 0, 0, 0, 0, 0, 1);
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL held_wait_req: got %0b want 1", imem_req); end
    @(negedge clock); drive(1, 0, 0, 0, 0, 0, 1);
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL held_req: got %0b want 0", imem_req); end
    n_cmp++; if (valid_f !== 1'b0) begin n_err++; $display("FAIL held_valid: got %0b want 0", valid_f); end
    @(negedge clock); drive(0, 0, 0, 0, 0, 0, 1);
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL held_release_req: got %0b want 0", imem_req); end
    @(negedge clock);
    n_cmp++; if (valid_f !== 1'b1 || pc_f !== RV + 8 || instr_f !== mem_word(RV + 8) || pc_plus4_f !== RV + 12)
      begin n_err++; $display("FAIL held_word: got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h", valid_f, pc_f, instr_f, RV + 8, mem_word(RV + 8)); end
    drive(0, 0, 0, 0, 0, 0, 1);
    n_cmp++; if (imem_addr !== RV + 12) begin n_err++; $display("FAIL held_next_addr: got %h want %h", imem_addr, RV + 12); end
    @(negedge clock);
    n_cmp++; if (valid_f !== 1'b1 || pc_f !== RV + 12) begin n_err++; $display("FAIL held_no_dup: got v=%0b pc=%h want v=1 pc=%h", valid_f, pc_f, RV + 12); end
  endtask

  task automatic test_wrap();
    restart();
    @(negedge clock); drive(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 1);
    @(negedge clock);
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_jump_addr: got %h want fffffffc", imem_addr); end
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clock);
    n_cmp++; if (valid_f !== 1'b1 || pc_f !== 32'hFFFF_FFFC || pc_plus4_f !== 32'h0)
      begin n_err++; $display("FAIL wrap_pc4: got v=%0b pc=%h pc4=%h want v=1 pc=fffffffc pc4=0", valid_f, pc_f, pc_plus4_f); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clock);
    n_cmp++; if (valid_f !== 1'b1 || pc_f !== 32'h0) begin n_err++; $display("FAIL wrap_next: got v=%0b pc=%h want v=1 pc=0", valid_f, pc_f); end
  endtask

`ifdef FETCH_EXCEPTION_EN
  task automatic test_exception();
    restart();
    @(negedge clock); drive(0, 0, 0, 1, 32'h0040_0300, 1, 1);
    @(negedge clock);
    n_cmp++; if (imem_addr !== EV || valid_f !== 1'b0) begin n_err++; $display("FAIL exc_prio: got addr=%h v=%0b want addr=%h v=0", imem_addr, valid_f, EV); end
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clock);
    n_cmp++; if (valid_f !== 1'b1 || pc_f !== EV) begin n_err++; $display("FAIL exc_word: got v=%0b pc=%h want v=1 pc=%h", valid_f, pc_f, EV); end
    drive(1, 0, 0, 0, 0, 1, 1);
    @(negedge clock);
    n_cmp++; if (imem_addr !== EV || valid_f !== 1'b0) begin n_err++; $display("FAIL exc_stall: got addr=%h v=%0b want addr=%h v=0", imem_addr, valid_f, EV); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] exp_pc, tgt, prev_addr, bt, jt;
    logic        prev_req, prev_ack, prev_redir, s, br, j, e, redir;
    int          consumed;
    restart();
    exp_pc = RV + 4; prev_req = 1'b0; prev_ack = 1'b0; prev_redir = 1'b0; prev_addr = 32'h0;
    consumed = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clock);
      if (prev_redir) begin
        n_cmp++; if (valid_f !== 1'b0) begin n_err++; $display("FAIL rnd_bubble[%0d]: got %0b want 0", cyc, valid_f); end
      end
      s  = ($urandom_range(99) < 30);
      br = ($urandom_range(99) < 10);
      j  = ($urandom_range(99) < 8);
      bt = $urandom; jt = $urandom;
`ifdef FETCH_EXCEPTION_EN
      e  = ($urandom_range(99) < 3);
`else
      e  = 1'b0;
`endif
      drive(s, br, bt, j, jt, e, ($urandom_range(99) < 60));
      if (prev_req && !prev_ack) begin
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== prev_addr)
          begin n_err++; $display("FAIL rnd_handshake[%0d]: got req=%0b addr=%h want req=1 addr=%h", cyc, imem_req, imem_addr, prev_addr); end
      end
      if (valid_f && !s) begin
        n_cmp++; if (pc_f !== exp_pc || instr_f !== mem_word(exp_pc) || pc_plus4_f !== exp_pc + 4)
          begin n_err++; $display("FAIL rnd_stream[%0d]: got pc=%h instr=%h want pc=%h instr=%h", cyc, pc_f, instr_f, exp_pc, mem_word(exp_pc)); end
        exp_pc = exp_pc + 4;
        consumed++;
      end
      redir = exc_req | (!s & (j | br));
      tgt   = exc_req ? EV : (j ? jt : bt);
      if (redir) exp_pc = tgt;
      prev_redir = redir; prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
    end
    n_cmp++; if (consumed < 50) begin n_err++; $display("FAIL rnd_progress: got %0d words want >= 50", consumed); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_branch();
    test_wait_jump();
    test_held();
    test_wrap();
`ifdef FETCH_EXCEPTION_EN
    test_exception();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
